instr_prefetch_buffer: RTL

//  Fetch front-end between a variable-latency instruction memory and the core's IF stage.

---
 rtl/instr_prefetch_buffer.sv | 90 +++++++++
 1 files changed

// File: rtl/instr_prefetch_buffer.sv
// instr_prefetch_buffer: sequential instruction fetcher feeding a DEPTH-entry FIFO, flushed on redirect
// Ports: clk/rstn (sync, active-low); mem_req/mem_addr/mem_ack/mem_rdata memory handshake;
//        redir_valid/redir_addr branch redirect; instr_valid/instr/instr_addr/instr_pop FIFO head to core.
module instr_prefetch_buffer #(
  parameter int          DEPTH      = 4,
  parameter logic [29:0] RESET_ADDR = 30'h0
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        mem_req,
  output logic [29:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        redir_valid,
  input  logic [29:0] redir_addr,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [29:0] instr_addr,
  input  logic        instr_pop
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;
  state_t      state;
  logic [29:0] fpc;
  logic [31:0] data_q [DEPTH];
  logic [29:0] addr_q [DEPTH];
  logic [AW-1:0] rd, wr;
  logic [AW:0] count, count_next;
  logic        push, pop;
  assign push        = rstn && !redir_valid && state == REQ && mem_ack;
  assign pop         = !redir_valid && instr_pop && count != '0;
  assign count_next  = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  assign instr_valid = count != '0;
  assign instr       = instr_valid ? data_q[rd] : 32'h0;
  assign instr_addr  = instr_valid ? addr_q[rd] : 30'h0;
  always_ff @(posedge clk)
    if (push) begin
      data_q[wr] <= mem_rdata;
      addr_q[wr] <= mem_addr;
    end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      fpc      <= RESET_ADDR;
      mem_req  <= 1'b0;
      mem_addr <= 30'h0;
      rd       <= '0;
      wr       <= '0;
      count    <= '0;
    end else if (redir_valid) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
      fpc   <= redir_addr;
      // an unanswered request must stay on the bus; its answer is discarded in DROP
      if (state == REQ && !mem_ack) begin
        state <= DROP;
      end else if (!(state == DROP && !mem_ack)) begin
        state    <= REQ;
        mem_req  <= 1'b1;
        mem_addr <= redir_addr;
      end
    end else begin
      if (push) wr <= wr + 1'b1;
      if (pop) rd <= rd + 1'b1;
      count <= count_next;
      case (state)
        IDLE: if (count < FULL) begin
          state    <= REQ;
          mem_req  <= 1'b1;
          mem_addr <= fpc;
        end
        REQ: if (mem_ack) begin
          fpc <= fpc + 30'd1;
          if (count_next < FULL) mem_addr <= fpc + 30'd1;
          else begin
            state   <= IDLE;
            mem_req <= 1'b0;
          end
        end
        DROP: if (mem_ack) begin
          state    <= REQ;
          mem_addr <= fpc;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
